// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Per-register producer scoreboard for an in-order pipeline with fixed
// write-back age. For every architectural register it tracks whether an
// in-flight producer exists, how many cycles ago it issued (age) and how
// many cycles that producer needs before its result can be forwarded (lat).
// From that state it decides, for the instruction waiting in ID, whether it
// must stall and, if not, which pipeline register to forward each operand
// from.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   id_valid     in   a valid instruction sits in ID/EX-issue
//   id_rs/id_rt  in   source register numbers (REG_AW bits each)
//   id_rs_en     in   rs is actually read
//   id_rt_en     in   rt is actually read
//   id_rd        in   destination register (REG_AW bits)
//   id_regWrite  in   the instruction writes id_rd
//   id_lat       in   producer latency 1..MAX_LAT (SW bits)
//   id_flush     in   squash the ID instruction this cycle
//   stall        out  hold ID, nothing issues this cycle
//   fwdA_sel     out  rs operand source: 0 = regfile, k = k stages past issue
//   fwdB_sel     out  rt operand source, same encoding
//   issue        out  the ID instruction enters EX this cycle
//   stall_cnt    out  saturating count of stall cycles (CNT_W bits)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW  = 4,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 16,
    parameter int SW      = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_en,
    input  logic              id_rt_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regWrite,
    input  logic [SW-1:0]     id_lat,
    input  logic              id_flush,
    output logic              stall,
    output logic [SW-1:0]     fwdA_sel,
    output logic [SW-1:0]     fwdB_sel,
    output logic              issue,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int NREG = 1 << REG_AW;
    localparam logic [SW-1:0]     AGE_LAST = SW'(MAX_LAT);
    localparam logic [SW-1:0]     SW_ZERO  = {SW{1'b0}};
    localparam logic [SW-1:0]     SW_ONE   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Scoreboard state, one entry per architectural register.
    logic              valid_r [NREG];
    logic [SW-1:0]     age_r   [NREG];
    logic [SW-1:0]     lat_r   [NREG];
    logic [CNT_W-1:0]  stall_cnt_r;

    // Source lookup results for the instruction in ID.
    logic              rs_hit_s;
    logic              rt_hit_s;
    logic              rs_haz_s;
    logic              rt_haz_s;
    logic              stall_s;
    logic              issue_s;
    logic              load_en_s;
    logic [SW-1:0]     fwd_a_s;
    logic [SW-1:0]     fwd_b_s;

    // Hazard detection and forward-select decode from pre-update state, so
    // an instruction reading its own destination sees the older producer.
    always_comb begin
        rs_hit_s  = 1'b0;
        rt_hit_s  = 1'b0;
        rs_haz_s  = 1'b0;
        rt_haz_s  = 1'b0;
        fwd_a_s   = SW_ZERO;
        fwd_b_s   = SW_ZERO;

        rs_hit_s = id_rs_en & (id_rs != REG_ZERO) & valid_r[id_rs];
        rt_hit_s = id_rt_en & (id_rt != REG_ZERO) & valid_r[id_rt];

        // A producer is still in flight until its age reaches its latency.
        rs_haz_s = rs_hit_s & (age_r[id_rs] < lat_r[id_rs]);
        rt_haz_s = rt_hit_s & (age_r[id_rt] < lat_r[id_rt]);

        if (rs_hit_s && !rs_haz_s) begin
            fwd_a_s = age_r[id_rs];
        end else begin
            fwd_a_s = SW_ZERO;
        end

        if (rt_hit_s && !rt_haz_s) begin
            fwd_b_s = age_r[id_rt];
        end else begin
            fwd_b_s = SW_ZERO;
        end
    end

    // Stall, issue and entry-load enable; a flushed instruction still
    // reports its stall but never issues or allocates an entry.
    always_comb begin
        stall_s   = 1'b0;
        issue_s   = 1'b0;
        load_en_s = 1'b0;

        stall_s   = id_valid & (rs_haz_s | rt_haz_s);
        issue_s   = id_valid & ~stall_s & ~id_flush;
        load_en_s = issue_s & id_regWrite & (id_rd != REG_ZERO);
    end

    assign stall    = stall_s;
    assign issue    = issue_s;
    assign fwdA_sel = fwd_a_s;
    assign fwdB_sel = fwd_b_s;
    assign stall_cnt = stall_cnt_r;

    // Entry update: a new producer overwrites the entry (it is always the
    // youngest), otherwise valid entries age and retire at write-back.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                valid_r[i] <= 1'b0;
                age_r[i]   <= SW_ZERO;
                lat_r[i]   <= SW_ZERO;
            end else if (load_en_s && (REG_AW'(i) == id_rd)) begin
                valid_r[i] <= 1'b1;
                age_r[i]   <= SW_ONE;
                lat_r[i]   <= id_lat;
            end else if (valid_r[i]) begin
                if (age_r[i] == AGE_LAST) begin
                    valid_r[i] <= 1'b0;
                    age_r[i]   <= SW_ZERO;
                    lat_r[i]   <= SW_ZERO;
                end else begin
                    age_r[i]   <= age_r[i] + SW_ONE;
                end
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard (REG_AW=4, MAX_LAT=4, CNT_W=16).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 2 units later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_rs_en;
    logic        id_rt_en;
    logic [3:0]  id_rd;
    logic        id_regWrite;
    logic [2:0]  id_lat;
    logic        id_flush;
    logic        stall;
    logic [2:0]  fwdA_sel;
    logic [2:0]  fwdB_sel;
    logic        issue;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(
        .REG_AW  (4),
        .MAX_LAT (4),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_en    (id_rs_en),
        .id_rt_en    (id_rt_en),
        .id_rd       (id_rd),
        .id_regWrite (id_regWrite),
        .id_lat      (id_lat),
        .id_flush    (id_flush),
        .stall       (stall),
        .fwdA_sel    (fwdA_sel),
        .fwdB_sel    (fwdB_sel),
        .issue       (issue),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // v rs rs_en rt rt_en rd regWrite lat flush
    task automatic drive(input logic v, input logic [3:0] rs, input logic rse,
                         input logic [3:0] rt, input logic rte, input logic [3:0] rd,
                         input logic wr, input logic [2:0] lat, input logic fl);
        id_valid    = v;
        id_rs       = rs;
        id_rs_en    = rse;
        id_rt       = rt;
        id_rt_en    = rte;
        id_rd       = rd;
        id_regWrite = wr;
        id_lat      = lat;
        id_flush    = fl;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        idle();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwdA", 32'(fwdA_sel), 32'd0);
        chk("rst_fwdB", 32'(fwdB_sel), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_issue", 32'(issue), 32'd0);

        // ALU r3 lat 1, then consumer rs=3 forwards from stage 1
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 3'd1, 1'b0);
        chk("alu_prod_issue", 32'(issue), 32'd1);
        tick();
        drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_fwdA", 32'(fwdA_sel), 32'd1);
        chk("alu_issue", 32'(issue), 32'd1);
        tick();

        // Load r5 lat 2, consumer rt=5 stalls one cycle then forwards stage 2
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 3'd2, 1'b0);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("ld_stall1", 32'(stall), 32'd1);
        chk("ld_issue1", 32'(issue), 32'd0);
        chk("ld_fwdB1", 32'(fwdB_sel), 32'd0);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("ld_stall2", 32'(stall), 32'd0);
        chk("ld_fwdB2", 32'(fwdB_sel), 32'd2);
        chk("ld_issue2", 32'(issue), 32'd1);
        chk("ld_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // r7 lat 1, two bubbles, consumer sees ages 3, 4, then retired
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 3'd1, 1'b0);
        tick();
        idle();
        tick();
        idle();
        tick();
        drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("age_fwdA3", 32'(fwdA_sel), 32'd3);
        tick();
        drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("age_fwdA4", 32'(fwdA_sel), 32'd4);
        tick();
        drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("age_fwdA0", 32'(fwdA_sel), 32'd0);
        chk("age_stall", 32'(stall), 32'd0);
        tick();

        // Two consecutive writers to r2, consumer sees the youngest on both ports
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 3'd1, 1'b0);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 3'd1, 1'b0);
        chk("waw_issue", 32'(issue), 32'd1);
        tick();
        drive(1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("waw_fwdA", 32'(fwdA_sel), 32'd1);
        chk("waw_fwdB", 32'(fwdB_sel), 32'd1);
        chk("waw_stall", 32'(stall), 32'd0);
        tick();

        // Lat-4 writer to r11 overwritten next cycle by a lat-1 writer: no stall
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1, 3'd4, 1'b0);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1, 3'd1, 1'b0);
        tick();
        drive(1'b1, 4'd11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("ovr_stall", 32'(stall), 32'd0);
        chk("ovr_fwdA", 32'(fwdA_sel), 32'd1);
        tick();

        // Writer to r0 creates nothing
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 3'd4, 1'b0);
        tick();
        drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("r0_stall", 32'(stall), 32'd0);
        chk("r0_fwdA", 32'(fwdA_sel), 32'd0);
        tick();

        // Lat-4 producer r12; disabled source masks the hazard
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12, 1'b1, 3'd4, 1'b0);
        tick();
        drive(1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("en0_stall", 32'(stall), 32'd0);
        chk("en0_issue", 32'(issue), 32'd1);
        // Same instruction flushed while hazardous: stall still reported
        drive(1'b1, 4'd12, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b1);
        chk("flush_stall", 32'(stall), 32'd1);
        chk("flush_issue", 32'(issue), 32'd0);
        tick();
        idle();
        chk("flush_cnt", 32'(stall_cnt), 32'd2);

        // Flushed writer to r13 never allocates
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd13, 1'b1, 3'd4, 1'b1);
        chk("flw_issue", 32'(issue), 32'd0);
        tick();
        drive(1'b1, 4'd13, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("flw_stall", 32'(stall), 32'd0);
        chk("flw_fwdA", 32'(fwdA_sel), 32'd0);
        tick();

        // r9 lat 4, then reset while a consumer is stalling on it
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 3'd4, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("rr_stall_pre", 32'(stall), 32'd1);
        tick();
        rst = 1'b0;
        drive(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0);
        chk("rr_stall", 32'(stall), 32'd0);
        chk("rr_fwdA", 32'(fwdA_sel), 32'd0);
        chk("rr_cnt", 32'(stall_cnt), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 4, giving the register-address width (2**REG_AW architectural registers, register 0 hardwired to zero).
REQ-002 SHALL have parameter MAX_LAT, default 4, giving the maximum producer latency in cycles from issue to a forwardable result; it is also the write-back age.
REQ-003 SHALL have parameter CNT_W, default 16, giving the stall-counter width; SW = clog2(MAX_LAT+1).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_valid  in  1  a valid instruction sits in ID/EX-issue.
REQ-008 id_rs, id_rt  in  REG_AW each  source register numbers.
REQ-009 id_rs_en, id_rt_en  in  1 each  the source is actually read.
REQ-010 id_rd  in  REG_AW  destination register.
REQ-011 id_regWrite  in  1  the instruction writes id_rd.
REQ-012 id_lat  in  SW  producer latency, legal range 1..MAX_LAT (1 = ALU, 2 = load, larger = multi-cycle unit).
REQ-013 id_flush  in  1  squash the ID instruction this cycle.
REQ-014 stall  out  1  hold ID; no issue this cycle.
REQ-015 fwdA_sel, fwdB_sel  out  SW each  0 = register file, k = pipeline register k stages past issue.
REQ-016 issue  out  1  the instruction enters EX this cycle.
REQ-017 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 SHALL keep one entry per register: valid bit, age (SW bits), lat (SW bits).
REQ-019 issue SHALL equal id_valid & ~stall & ~id_flush, computed combinationally.
REQ-020 On issue with id_regWrite=1 and id_rd!=0, entry[id_rd] SHALL be loaded with valid=1, age=1, lat=id_lat at the next edge, overwriting any existing entry for that register.
REQ-021 Every other valid entry SHALL increment age each cycle; an entry with age==MAX_LAT SHALL clear valid at the next edge, since the register file is then written.
REQ-022 When issue to a register coincides with that entry's aging or clearing, the new load SHALL win.
REQ-023 Source r is hazardous when its enable=1, r!=0, entry[r].valid and entry[r].age < entry[r].lat.
REQ-024 stall SHALL be id_valid & (rs hazard | rt hazard), combinational from current state; id_flush SHALL NOT be masked out of stall.
REQ-025 fwdA_sel SHALL be entry[id_rs].age when id_rs_en, id_rs!=0, the entry is valid and no hazard exists; otherwise 0. fwdB_sel SHALL follow the same rule for id_rt.
REQ-026 Sources SHALL be resolved against state before this cycle's update, so an instruction reading its own id_rd sees the older producer.
REQ-027 Ordering is in-order and write-back age is fixed, so the entry always names the youngest producer; a WAW hazard SHALL NOT cause a stall.
REQ-028 stall_cnt SHALL increment on every cycle with stall=1 and SHALL saturate at all-ones.
REQ-029 id_lat outside 1..MAX_LAT is illegal; behaviour is unspecified.

Reset
REQ-030 On rst=1 at an edge, all entries SHALL be cleared (valid=0, age=0, lat=0) and stall_cnt SHALL be set to 0, overriding any concurrent issue.
REQ-031 After reset, stall=0, fwdA_sel=0 and fwdB_sel=0 until a producer issues.

Verification (REG_AW=4, MAX_LAT=4)
REQ-032 Issue ALU r3, lat 1; next cycle a consumer with rs=3 -> stall=0, fwdA_sel=1, issue=1.
REQ-033 Issue load r5, lat 2; next cycle a consumer with rt=5 -> stall=1 for one cycle, then fwdB_sel=2, stall_cnt=1.
REQ-034 Issue r7, lat 1; then two bubbles; then a consumer with rs=7 -> fwdA_sel=3. The same consumer one cycle later -> fwdA_sel=4; two cycles later -> fwdA_sel=0.
REQ-035 Issue writers to r2 on two consecutive cycles, both lat 1; then a consumer with rs=2 and rt=2 -> fwdA_sel=fwdB_sel=1.
REQ-036 Issue a writer with rd=0; then a consumer with rs=0 -> no entry created, stall=0, fwdA_sel=0. A lat-4 producer with a hazard blocked by id_rs_en=0 -> stall=0.
REQ-037 Issue r9, lat 4; assert rst the next cycle while a consumer with rs=9 is stalling -> after the edge stall=0, fwdA_sel=0, stall_cnt=0.
